// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-channel round-robin arbiter.
// Holds the FSM state encoding and the channel/select widths.
package arb_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [NUM_CH-1:0] onehot(
        input logic [SEL_W-1:0] i
    );
        logic [NUM_CH-1:0] v;
        v = {{(NUM_CH-1){1'b0}}, 1'b1};
        return v << i;
    endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the arbiter.
// slave is the arbiter side, master the requester side.
interface rr_arbiter4_if;
    import arb_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              done;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  sel;
    logic              valid;
    logic              timeout;

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output valid,
        output timeout
    );

    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  valid,
        input  timeout
    );
endinterface

// File: rtl/rr_pick4.sv
// Rotating-priority pick: first set request at or after ptr, mod 4.
// Purely combinational.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic              o_found,
    output logic [SEL_W-1:0]  o_idx
);

    logic [SEL_W-1:0] w_c;

    // Scan from lowest priority to highest so the last hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        w_c     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_c = i_ptr + SEL_W'(k);
            if (i_req[w_c]) begin
                o_found = 1'b1;
                o_idx   = w_c;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-channel round-robin arbiter with hold timeout and no preemption.
// All outputs come straight from registers.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter4_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    arb_state_t        r_state, w_state_nx;
    logic [SEL_W-1:0]  r_ptr, w_ptr_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [NUM_CH-1:0] r_grant, w_grant_nx;
    logic [SEL_W-1:0]  r_sel, w_sel_nx;
    logic              r_valid, w_valid_nx;
    logic              r_tmo, w_tmo_nx;

    logic              w_found;
    logic [SEL_W-1:0]  w_idx;
    logic              w_own_req;
    logic              w_expire;
    logic              w_release;

    rr_pick4 u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_own_req = bus.req[r_sel];
    assign w_expire  = (r_cnt == CNT_MAX);
    assign w_release = bus.done | ~w_own_req | w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_cnt   <= w_cnt_nx;
            r_grant <= w_grant_nx;
            r_sel   <= w_sel_nx;
            r_valid <= w_valid_nx;
            r_tmo   <= w_tmo_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        w_grant_nx = r_grant;
        w_sel_nx   = r_sel;
        w_valid_nx = r_valid;
        w_tmo_nx   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_grant_nx = '0;
                w_valid_nx = 1'b0;
                if (w_found) begin
                    w_state_nx = BUSY;
                    w_grant_nx = onehot(w_idx);
                    w_sel_nx   = w_idx;
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = '0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_state_nx = IDLE;
                    w_grant_nx = '0;
                    w_valid_nx = 1'b0;
                    w_cnt_nx   = '0;
                    w_ptr_nx   = r_sel + 1'b1;
                    // Flag only releases forced purely by the counter.
                    w_tmo_nx   = w_expire & ~bus.done & w_own_req;
                end else begin
                    w_cnt_nx   = r_cnt + 1'b1;
                end
            end
        endcase
    end

    assign bus.grant   = r_grant;
    assign bus.sel     = r_sel;
    assign bus.valid   = r_valid;
    assign bus.timeout = r_tmo;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: directed scenarios then random traffic
// checked against a cycle-level behavioural model.
module tb_rr_arbiter4;

    localparam int TMO = 4;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
        logic       t;
    } exp_t;

    logic clk;
    logic rst_n;
    rr_arbiter4_if bus ();

    rr_arbiter4 #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // Model: owner channel (-1 when idle), cycles held so far, last owner.
    int m_owner, m_held, m_last, m_ptr;
    logic m_tmo;

    task automatic chk(input string name, input int act, input int req_v);
        n_checks++;
        if (act != req_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, req_v);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 0;
        m_ptr   = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic d);
        bit found;
        bit expd;
        int c;
        if (m_owner < 0) begin
            m_tmo = 1'b0;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!found && r[c]) begin
                    found   = 1;
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                end
            end
        end else begin
            expd = (m_held == TMO);
            if (d || !r[m_owner] || expd) begin
                m_tmo   = expd && !d && r[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_held++;
                m_tmo = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        exp_t e;
        bus.req  = r;
        bus.done = d;
        model_edge(r, d);
        e.g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.s = 2'(m_last);
        e.v = (m_owner >= 0);
        e.t = m_tmo;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare every registered output just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant",   int'(bus.grant),   int'(e.g));
                chk("sel",     int'(bus.sel),     int'(e.s));
                chk("valid",   int'(bus.valid),   int'(e.v));
                chk("timeout", int'(bus.timeout), int'(e.t));
            end
        end
    end

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        chk("rst_grant",   int'(bus.grant),   0);
        chk("rst_sel",     int'(bus.sel),     0);
        chk("rst_valid",   int'(bus.valid),   0);
        chk("rst_timeout", int'(bus.timeout), 0);
        model_reset();
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        logic       d;
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_now();

        // Basic grant, release on done, pointer advance.
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b1);
        step(4'b0000, 1'b0);

        // Continuous requests, done each grant: strict rotation.
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b1);
        end

        // Held request, no done: forced release and re-grant.
        repeat (12) step(4'b0001, 1'b0);

        // Owner drops early; sel holds while idle.
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // Req drop or done coinciding with expiry: no timeout pulse.
        repeat (4) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        repeat (4) step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b0);

        // Reset mid-grant on ch2, then ptr restarts at 0.
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        reset_now();
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);

        // Ch3 release wraps ptr to 0.
        step(4'b1001, 1'b0);
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b0);
        step(4'b1001, 1'b1);

        // Random traffic; requests mostly persist so timeouts occur.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            d = ($urandom_range(5) == 0);
            step(r, d);
            if (i == 200) reset_now();
        end

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
